// File: rtl/iter_shifter_if.sv
// Operand/result bundle for iter_shifter.
//   start      request, sampled only when the unit is accepting
//   in         operand
//   shift      shift amount 0..WIDTH-1
//   direction  1 = right, 0 = left
//   signex     1 = arithmetic right shift, 0 = logical
//   out        registered result of the last completed operation
//   busy       high while shifting
//   done       one-cycle completion pulse
interface iter_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shift;
  logic             direction;
  logic             signex;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, in, shift, direction, signex,
    input  out, busy, done
  );

  modport slave (
    input  start, in, shift, direction, signex,
    output out, busy, done
  );
endinterface

// File: rtl/iter_shifter.sv
// Iterative one-bit-per-cycle barrel-shifter replacement.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    iter_shifter_if slave: start/in/shift/direction/signex in, out/busy/done out
// An accepted start with shift N spends N cycles in StShift, then one cycle in StDone
// with done high; out is updated on entry to StDone and held otherwise.
module iter_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHW-1:0] CntZero = '0;
  localparam logic [SHW-1:0] CntOne  = SHW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          work_d  = bus.in;
          cnt_d   = bus.shift;
          dir_d   = bus.direction;
          // Right-arithmetic fill is the captured MSB; every other mode fills with zero.
          fill_d  = bus.direction & bus.signex & bus.in[WIDTH-1];
          state_d = (bus.shift == CntZero) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (dir_q) begin
          work_d = {fill_q, work_q[WIDTH-1:1]};
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // StDone is only ever the next state on entry, so this loads out exactly once per op.
    if (state_d == StDone) begin
      out_d = work_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width of the operand and result.
REQ-002 Parameter SHW, default 5, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only when the unit is accepting (REQ-012).
REQ-006 in  input  WIDTH  operand, captured on an accepted start.
REQ-007 shift  input  SHW  shift amount 0..WIDTH-1, captured on an accepted start.
REQ-008 direction  input  1  1 = right shift, 0 = left shift; captured on an accepted start.
REQ-009 signex  input  1  1 = arithmetic on right shifts, 0 = logical; ignored for left shifts; captured on an accepted start.
REQ-010 out  output  WIDTH  registered result of the last completed operation.
REQ-011 busy  output  1  high while in state SHIFT; done  output  1  one-cycle completion pulse.

Function
REQ-012 States IDLE, SHIFT, DONE; start SHALL be accepted only in IDLE or DONE, and ignored in SHIFT.
REQ-013 On accepted start: latch in, direction and signex into a working register and flags; load a counter with shift.
REQ-014 Accepted start with shift != 0 -> SHIFT next cycle; with shift == 0 -> DONE next cycle, result = in.
REQ-015 Each SHIFT cycle: shift the working register exactly one bit and decrement the counter; the cycle the counter goes 1 -> 0 SHALL transition to DONE.
REQ-016 Left shift: fill LSB with 0. Right logical: fill MSB with 0. Right arithmetic: replicate the captured MSB.
REQ-017 On entry to DONE, out SHALL load the final working-register value; out SHALL otherwise hold its value, including throughout SHIFT.
REQ-018 done SHALL be high for exactly the DONE cycle. DONE -> SHIFT or DONE on accepted start, per REQ-014; otherwise DONE -> IDLE.
REQ-019 Latency: done SHALL assert shift+1 cycles after the edge that accepts start (shift=0: 1 cycle; shift=31: 32 cycles).
REQ-020 Input changes after acceptance SHALL NOT affect the operation in flight.
REQ-021 Back-to-back: start held high in DONE SHALL begin the next operation with no idle cycle.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, out = 0, busy = 0, done = 0, counter = 0, working register = 0, regardless of the clock.
REQ-023 Reset during SHIFT SHALL abandon the operation with no done pulse; the first accepted start after deassertion SHALL behave as from power-up.
REQ-024 start SHALL be ignored while rst_n is low.

Verification
REQ-025 in=FFFFFFFD, shift=1, direction=1, signex=1, start pulse -> busy 1 cycle, done 2 cycles after acceptance, out=FFFFFFFE.
REQ-026 Same operand with signex=0 -> out=7FFFFFFE; direction=0, shift=4, in=0000000F -> out=000000F0 with done at cycle 5.
REQ-027 shift=0, in=12345678 -> no busy, done next cycle, out=12345678; shift=31 right arithmetic, in=80000000 -> out=FFFFFFFF, done at cycle 32.
REQ-028 start pulsed with new operands mid-SHIFT -> ignored; result and latency match the first operation only.
REQ-029 rst_n pulsed low mid-SHIFT (shift=20) -> out=0, busy=0 asynchronously, no done; a fresh start then completes normally.
REQ-030 start held high continuously with shift=2 -> done every 3 cycles and busy never idle between operations; out matches a reference model after each done.
